lemming_dig_scheduler: RTL and testbench

//  Controller for a group of NUM_LEM walking lemmings that share a single dig tool.

---
 rtl/lemming_dig_scheduler.sv | 134 +++++++++++++
 tb/tb_lemming_dig_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lemming_dig_scheduler.sv
// Walk-direction keeper and round-robin dig-tool arbiter for a group of lemmings.
// Each lemming is a small Moore FSM; one shared counter times the active dig.
module lemming_dig_scheduler #(
    parameter int  NUM_LEM    = 4,
    parameter int  DIG_CYCLES = 3,
    localparam int ID_W       = $clog2(NUM_LEM)
) (
    input  logic                clk,
    input  logic                areset,
    input  logic [NUM_LEM-1:0]  bump_left,
    input  logic [NUM_LEM-1:0]  bump_right,
    input  logic [NUM_LEM-1:0]  dig_req,
    output logic [NUM_LEM-1:0]  walk_left,
    output logic [NUM_LEM-1:0]  walk_right,
    output logic [NUM_LEM-1:0]  digging,
    output logic                dig_busy,
    output logic [ID_W-1:0]     dig_grant_id
);

    localparam int CNT_W = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

    typedef enum logic [1:0] {
        WALK_L = 2'd0,
        WALK_R = 2'd1,
        DIG    = 2'd2
    } lem_state_t;

    lem_state_t          state_reg  [NUM_LEM];
    lem_state_t          state_next [NUM_LEM];
    logic [NUM_LEM-1:0]  saved_right_reg;
    logic [NUM_LEM-1:0]  saved_right_next;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    count_next;
    logic [ID_W-1:0]     grant_id_reg;
    logic [ID_W-1:0]     grant_id_next;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     rr_ptr_next;

    logic [NUM_LEM-1:0]  eligible;
    logic [NUM_LEM-1:0]  grant_onehot;
    logic                tool_free;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_idx;
    logic                release_now;

    assign dig_busy     = |digging;
    assign dig_grant_id = grant_id_reg;
    // Only one lemming can be in DIG, so the shared counter reaching zero marks its last cycle.
    assign release_now  = dig_busy && (count_reg == '0);
    assign tool_free    = !dig_busy || release_now;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEM; gi++) begin : g_lem
            assign walk_left[gi]  = (state_reg[gi] == WALK_L);
            assign walk_right[gi] = (state_reg[gi] == WALK_R);
            assign digging[gi]    = (state_reg[gi] == DIG);
            assign eligible[gi]   = dig_req[gi] && (state_reg[gi] != DIG);
            assign grant_onehot[gi] = grant_valid && (int'(grant_idx) == gi);

            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    state_reg[gi]       <= WALK_L;
                    saved_right_reg[gi] <= 1'b0;
                end else begin
                    state_reg[gi]       <= state_next[gi];
                    saved_right_reg[gi] <= saved_right_next[gi];
                end
            end

            always_comb begin
                state_next[gi]       = state_reg[gi];
                saved_right_next[gi] = saved_right_reg[gi];
                if (grant_onehot[gi]) begin
                    state_next[gi]       = DIG;
                    saved_right_next[gi] = (state_reg[gi] == WALK_R);
                end else begin
                    case (state_reg[gi])
                        WALK_L: if (bump_left[gi])  state_next[gi] = WALK_R;
                        WALK_R: if (bump_right[gi]) state_next[gi] = WALK_L;
                        DIG: begin
                            if (count_reg == '0)
                                state_next[gi] = saved_right_reg[gi] ? WALK_R : WALK_L;
                        end
                        default: state_next[gi] = WALK_L;
                    endcase
                end
            end
        end
    endgenerate

    // Cyclic first-eligible scan starting at the round-robin pointer.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (tool_free) begin
            for (int k = 0; k < NUM_LEM; k++) begin
                idx = (int'(rr_ptr_reg) + k) % NUM_LEM;
                if (!grant_valid && eligible[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        count_next    = count_reg;
        grant_id_next = grant_id_reg;
        rr_ptr_next   = rr_ptr_reg;
        if (grant_valid) begin
            count_next    = CNT_W'(DIG_CYCLES - 1);
            grant_id_next = grant_idx;
            rr_ptr_next   = (int'(grant_idx) == NUM_LEM - 1) ? '0 : grant_idx + 1'b1;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count_reg    <= '0;
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            count_reg    <= count_next;
            grant_id_reg <= grant_id_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_lemming_dig_scheduler.sv
// Bench for lemming_dig_scheduler: directed stimulus, a cycle-level reference model
// (owner / cycles-left / direction table) compared on every falling edge, plus literal checks.
module tb_lemming_dig_scheduler;

    localparam int N = 4;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         areset = 1'b0;
    logic [N-1:0] bump_left = '0;
    logic [N-1:0] bump_right = '0;
    logic [N-1:0] dig_req = '0;
    logic [N-1:0] walk_left;
    logic [N-1:0] walk_right;
    logic [N-1:0] digging;
    logic         dig_busy;
    logic [1:0]   dig_grant_id;

    lemming_dig_scheduler #(.NUM_LEM(N), .DIG_CYCLES(D)) dut (
        .clk          (clk),
        .areset       (areset),
        .bump_left    (bump_left),
        .bump_right   (bump_right),
        .dig_req      (dig_req),
        .walk_left    (walk_left),
        .walk_right   (walk_right),
        .digging      (digging),
        .dig_busy     (dig_busy),
        .dig_grant_id (dig_grant_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: direction per lemming (1 = right), current dig owner and cycles it has left.
    bit m_right [N];
    int m_owner;
    int m_left;
    int m_rr;
    int m_gid;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < N; i++) m_right[i] = 1'b0;
            m_owner = -1;
            m_left  = 0;
            m_rr    = 0;
            m_gid   = 0;
        end else begin
            int g;
            bit rel;
            g   = -1;
            rel = (m_owner >= 0) && (m_left == 1);
            if (m_owner < 0 || rel) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    if (g < 0 && dig_req[i] && i != m_owner) g = i;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (i != m_owner && i != g) begin
                    if (!m_right[i] && bump_left[i])      m_right[i] = 1'b1;
                    else if (m_right[i] && bump_right[i]) m_right[i] = 1'b0;
                end
            end
            if (rel)               m_owner = -1;
            else if (m_owner >= 0) m_left  = m_left - 1;
            if (g >= 0) begin
                m_owner = g;
                m_left  = D;
                m_gid   = g;
                m_rr    = (g + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_wl, e_wr, e_dg;
        for (int i = 0; i < N; i++) begin
            e_dg[i] = (m_owner == i);
            e_wl[i] = !e_dg[i] && !m_right[i];
            e_wr[i] = !e_dg[i] && m_right[i];
        end
        chk("model_walk_left",  32'(walk_left),    32'(e_wl));
        chk("model_walk_right", 32'(walk_right),   32'(e_wr));
        chk("model_digging",    32'(digging),      32'(e_dg));
        chk("model_dig_busy",   32'(dig_busy),     32'(m_owner >= 0));
        chk("model_grant_id",   32'(dig_grant_id), 32'(m_gid));
        $display("[TB] t=%0t bl=%b br=%b req=%b wl=%b wr=%b dig=%b busy=%b id=%0d",
                 $time, bump_left, bump_right, dig_req, walk_left, walk_right,
                 digging, dig_busy, dig_grant_id);
    end

    // Apply inputs, take one rising edge, and return just after it.
    task automatic tick(input logic [N-1:0] bl, input logic [N-1:0] br, input logic [N-1:0] rq);
        bump_left  = bl;
        bump_right = br;
        dig_req    = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 areset = 1'b1;
        #1;
        chk("por_walk_left", 32'(walk_left), 32'h0000000f);
        chk("por_digging",   32'(digging),   32'h0);
        @(posedge clk);
        #1 areset = 1'b0;

        // Asynchronous reset between edges
        tick(4'b1111, 4'b0000, 4'b0000);
        chk("t1_all_right", 32'(walk_right), 32'h0000000f);
        #1 areset = 1'b1;
        #1;
        chk("t1_walk_left", 32'(walk_left),    32'h0000000f);
        chk("t1_digging",   32'(digging),      32'h0);
        chk("t1_grant_id",  32'(dig_grant_id), 32'h0);
        #1 areset = 1'b0;

        // Single-side bumps
        tick(4'b0100, 4'b0000, 4'b0000);
        chk("t2_turn_right", 32'(walk_right), 32'h4);
        tick(4'b0100, 4'b0000, 4'b0000);
        chk("t2_left_ignored", 32'(walk_right), 32'h4);
        tick(4'b0000, 4'b0100, 4'b0000);
        chk("t2_turn_left", 32'(walk_left), 32'hf);

        // Back-to-back round robin between lemmings 1 and 2
        tick(4'b0000, 4'b0000, 4'b0110);
        chk("t3_dig1",  32'(digging),      32'h2);
        chk("t3_id1",   32'(dig_grant_id), 32'h1);
        chk("t3_busy",  32'(dig_busy),     32'h1);
        tick(4'b0000, 4'b0000, 4'b0110);
        tick(4'b0000, 4'b0000, 4'b0110);
        chk("t3_dig1_c3", 32'(digging), 32'h2);
        tick(4'b0000, 4'b0000, 4'b0110);
        chk("t3_dig2",  32'(digging),      32'h4);
        chk("t3_id2",   32'(dig_grant_id), 32'h2);
        tick(4'b0000, 4'b0000, 4'b0110);
        tick(4'b0000, 4'b0000, 4'b0110);
        chk("t3_dig2_c3", 32'(digging), 32'h4);
        tick(4'b0000, 4'b0000, 4'b0110);
        chk("t3_dig1_again", 32'(digging),      32'h2);
        chk("t3_id1_again",  32'(dig_grant_id), 32'h1);
        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);
        chk("t3_req_drop_runs_on", 32'(digging), 32'h2);
        tick(4'b0000, 4'b0000, 4'b0000);
        chk("t3_idle",    32'(dig_busy),     32'h0);
        chk("t3_id_hold", 32'(dig_grant_id), 32'h1);

        // Lemming 0 walking right, bumped right on its grant edge
        tick(4'b0001, 4'b0000, 4'b0000);
        chk("t4_right", 32'(walk_right), 32'h1);
        tick(4'b0000, 4'b0001, 4'b0001);
        chk("t4_dig0", 32'(digging),      32'h1);
        chk("t4_id0",  32'(dig_grant_id), 32'h0);
        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);
        chk("t4_back_right", 32'(walk_right), 32'h1);
        chk("t4_others_left", 32'(walk_left), 32'he);

        // Reset in the middle of a dig also resets the round-robin pointer
        tick(4'b0000, 4'b0000, 4'b0001);
        chk("t5_dig0", 32'(digging), 32'h1);
        tick(4'b0000, 4'b0000, 4'b0000);
        #1 areset = 1'b1;
        #1;
        chk("t5_digging",   32'(digging),   32'h0);
        chk("t5_busy",      32'(dig_busy),  32'h0);
        chk("t5_walk_left", 32'(walk_left), 32'hf);
        #1 areset = 1'b0;
        tick(4'b0000, 4'b0000, 4'b1001);
        chk("t5_rr_reset", 32'(digging), 32'h1);
        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);

        // Both bumps on walking vs digging lemmings
        tick(4'b1000, 4'b1000, 4'b0000);
        chk("t6_flip_r", 32'(walk_right), 32'h8);
        tick(4'b1000, 4'b1000, 4'b0000);
        chk("t6_flip_l", 32'(walk_right), 32'h0);
        tick(4'b0000, 4'b0000, 4'b0010);
        chk("t6_dig1", 32'(digging), 32'h2);
        tick(4'b0010, 4'b0010, 4'b0000);
        chk("t6_bump_ignored", 32'(digging), 32'h2);
        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);
        chk("t6_back_left", 32'(walk_left), 32'hf);

        tick(4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
